// File: rtl/mips_program_runner.sv
`timescale 1ns/1ps
// Program-load / run / check sequencer for the pipelined MIPS32 core.
// Streams a sparse image into memory, runs the core until halt or timeout, then checks result words.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset, all outputs low, waiting for start
// S_LOAD  | one fill cycle, then one image write per cycle
// S_RUN   | core released and owns memory, cycles counted
// S_CHECK | result addresses read back, compared one cycle later
// S_DONE  | results held, start begins a new run
module mips_program_runner #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int PRELOAD_LEN = 16,
   parameter int NUM_CHECKS  = 2,
   parameter int TIMEOUT     = 1024,
   localparam int IW = (PRELOAD_LEN > 1) ? $clog2(PRELOAD_LEN) : 1,
   localparam int KW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int FW = $clog2(NUM_CHECKS + 1),
   localparam int CW = $clog2(TIMEOUT + 1)
) (
   input  logic                     clk1,
   input  logic                     reset,
   input  logic                     start,
   output logic [IW-1:0]            img_idx,
   input  logic [ADDR_W+DATA_W-1:0] img_data,
   output logic [KW-1:0]            chk_idx,
   input  logic [ADDR_W-1:0]        chk_addr,
   input  logic [DATA_W-1:0]        chk_expect,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     core_run,
   input  logic                     core_halted,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     timed_out,
   output logic [FW-1:0]            fail_count,
   output logic [CW-1:0]            cycle_count
);

   localparam int LW = $clog2(PRELOAD_LEN + 1);

   localparam logic [LW-1:0] LD_LAST  = LW'(PRELOAD_LEN);
   localparam logic [FW-1:0] CK_END   = FW'(NUM_CHECKS);
   localparam logic [FW-1:0] FAIL_MAX = FW'(NUM_CHECKS);
   localparam logic [CW-1:0] CYC_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   state_t              state;
   logic [LW-1:0]       ld_cnt;
   logic [FW-1:0]       ck_cnt;
   logic [DATA_W-1:0]   exp_q;

   always_ff @(posedge clk1) begin
      if (reset) begin
         state       <= S_IDLE;
         ld_cnt      <= '0;
         ck_cnt      <= '0;
         exp_q       <= '0;
         cycle_count <= '0;
         fail_count  <= '0;
         timed_out   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_LOAD;
                  ld_cnt      <= '0;
                  ck_cnt      <= '0;
                  cycle_count <= '0;
                  fail_count  <= '0;
                  timed_out   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (ld_cnt == LD_LAST) begin
                  state  <= S_RUN;
                  ld_cnt <= '0;
               end else begin
                  ld_cnt <= ld_cnt + LW'(1);
               end
            end
            S_RUN: begin
               // a halt seen in the same cycle as the timeout still gets checked
               if (core_halted) begin
                  state <= S_CHECK;
               end else begin
                  if (cycle_count != CYC_MAX)
                     cycle_count <= cycle_count + CW'(1);
                  if (cycle_count == CYC_LAST) begin
                     state     <= S_DONE;
                     timed_out <= 1'b1;
                  end
               end
            end
            S_CHECK: begin
               if (ck_cnt != CK_END)
                  exp_q <= chk_expect;
               if (ck_cnt != '0 && mem_rdata != exp_q && fail_count != FAIL_MAX)
                  fail_count <= fail_count + FW'(1);
               if (ck_cnt == CK_END) begin
                  state  <= S_DONE;
                  ck_cnt <= '0;
               end else begin
                  ck_cnt <= ck_cnt + FW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state == S_LOAD) || (state == S_RUN) || (state == S_CHECK);
   assign done     = (state == S_DONE);
   assign core_run = (state == S_RUN);
   assign pass     = done && !timed_out && (fail_count == '0);

   assign img_idx  = (state == S_LOAD && ld_cnt != LD_LAST) ? ld_cnt[IW-1:0] : '0;
   assign chk_idx  = (state == S_CHECK && ck_cnt != CK_END) ? ck_cnt[KW-1:0] : '0;

   // image data arrives one cycle after its index, so writes trail img_idx by one
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_LOAD: begin
            if (ld_cnt != '0) begin
               mem_we    = 1'b1;
               mem_addr  = img_data[ADDR_W+DATA_W-1:DATA_W];
               mem_wdata = img_data[DATA_W-1:0];
            end
         end
         S_CHECK: begin
            if (ck_cnt != CK_END)
               mem_addr = chk_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_program_runner.sv
`timescale 1ns/1ps
// Bench for mips_program_runner: fixed scenario table, corner sequences, then randomized runs
// checked against an image/memory reference model.
module tb_mips_program_runner;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int PL = 16;
   localparam int NC = 2;
   localparam int TO = 64;

   logic           clk1 = 1'b0;
   logic           reset, start;
   logic [3:0]     img_idx;
   logic [AW+DW-1:0] img_data;
   logic [0:0]     chk_idx;
   logic [AW-1:0]  chk_addr;
   logic [DW-1:0]  chk_expect;
   logic           mem_we;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_wdata, mem_rdata;
   logic           core_run, core_halted, busy, done, pass, timed_out;
   logic [1:0]     fail_count;
   logic [6:0]     cycle_count;

   always #5 clk1 = ~clk1;

   mips_program_runner #(.DATA_W(DW), .ADDR_W(AW), .PRELOAD_LEN(PL), .NUM_CHECKS(NC), .TIMEOUT(TO)) dut (
      .clk1(clk1), .reset(reset), .start(start),
      .img_idx(img_idx), .img_data(img_data),
      .chk_idx(chk_idx), .chk_addr(chk_addr), .chk_expect(chk_expect),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .core_run(core_run), .core_halted(core_halted),
      .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
      .fail_count(fail_count), .cycle_count(cycle_count)
   );

   // image ROM with one cycle of read latency, combinational check table
   logic [AW+DW-1:0] img_tab [PL];
   logic [AW-1:0]    chk_a   [NC];
   logic [DW-1:0]    chk_e   [NC];
   always @(posedge clk1) img_data <= img_tab[img_idx];
   assign chk_addr   = chk_a[chk_idx];
   assign chk_expect = chk_e[chk_idx];

   // memory plus a core model: on its first run cycle it computes MEM[121] = MEM[120] + 45
   logic [DW-1:0] mem [1<<AW];
   logic          clr;
   int            rc;
   int            halt_at;
   always @(posedge clk1) begin
      if (clr) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         if (core_run && rc == 0) mem[121] <= mem[120] + 32'd45;
      end
      mem_rdata <= mem[mem_addr];
   end
   always @(posedge clk1) rc <= core_run ? rc + 1 : 0;
   assign core_halted = core_run && (rc >= halt_at);

   int   run_cyc, post_busy, we_cnt;
   logic seen_run, mon_clr;
   always @(posedge clk1) begin
      if (mon_clr) begin
         run_cyc <= 0; post_busy <= 0; we_cnt <= 0; seen_run <= 1'b0;
      end else begin
         if (core_run) begin run_cyc <= run_cyc + 1; seen_run <= 1'b1; end
         if (busy && !core_run && seen_run) post_busy <= post_busy + 1;
         if (mem_we) we_cnt <= we_cnt + 1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_run(input int pulse_at, output bit ok);
      int k;
      k  = 0;
      ok = 1'b1;
      @(negedge clk1); start = 1'b1; mon_clr = 1'b1;
      @(negedge clk1); start = 1'b0; mon_clr = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("we_fill_cycle", mem_we, 0);
      @(negedge clk1);
      chk("we_first_write", mem_we, 1);
      for (int i = 0; i < 400 && !done; i++) begin
         start = (core_run && k == pulse_at);
         if (core_run) k++;
         @(negedge clk1);
      end
      start = 1'b0;
      if (!done) begin
         chk("done_reached", 0, 1);
         ok = 1'b0;
      end
   endtask

   task automatic check_res(input string tag, input bit p, input int f, input int cy, input bit t);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_pass"}, pass, p);
      chk({tag, "_fail_count"}, fail_count, f);
      chk({tag, "_cycle_count"}, cycle_count, cy);
      chk({tag, "_timed_out"}, timed_out, t);
      chk({tag, "_run_cycles"}, run_cyc, t ? TO : cy + 1);
      chk({tag, "_check_cycles"}, post_busy, t ? 0 : NC + 1);
      chk({tag, "_writes"}, we_cnt, PL);
   endtask

   typedef struct {
      int          halt;
      logic [31:0] e0;
      logic [31:0] e1;
      bit          p;
      int          fails;
      int          cyc;
      bit          t;
   } vec_t;
   vec_t vecs [7];

   logic [DW-1:0] ref_mem [1<<AW];

   initial begin
      bit          ok;
      logic [9:0]  a;
      logic [31:0] d;
      bit          exp_t;
      int          exp_f, exp_cy;

      reset = 1'b1; start = 1'b0; clr = 1'b1; mon_clr = 1'b1; halt_at = 1000;

      // program words 0..9, then 120 written twice: the later value must win
      for (int i = 0; i < 10; i++) img_tab[i] = {10'(i), 32'h2000_0000 + 32'(i)};
      img_tab[10] = {10'd120, 32'd5};
      img_tab[11] = {10'd120, 32'd100};
      for (int i = 12; i < PL; i++) img_tab[i] = {10'(300 + i), 32'(i)};
      chk_a[0] = 10'd121;
      chk_a[1] = 10'd120;
      chk_e[0] = 32'd145;
      chk_e[1] = 32'd100;

      vecs[0] = '{40,   32'd145, 32'd100, 1'b1, 0, 40, 1'b0};
      vecs[1] = '{40,   32'd146, 32'd100, 1'b0, 1, 40, 1'b0};
      vecs[2] = '{40,   32'd146, 32'd99,  1'b0, 2, 40, 1'b0};
      vecs[3] = '{1000, 32'd145, 32'd100, 1'b0, 0, 64, 1'b1};
      vecs[4] = '{63,   32'd145, 32'd100, 1'b1, 0, 63, 1'b0};
      vecs[5] = '{0,    32'd145, 32'd100, 1'b1, 0, 0,  1'b0};
      vecs[6] = '{64,   32'd145, 32'd100, 1'b0, 0, 64, 1'b1};

      repeat (3) @(posedge clk1);
      @(negedge clk1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timed_out", timed_out, 0);
      chk("rst_core_run", core_run, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_img_idx", img_idx, 0);
      chk("rst_chk_idx", chk_idx, 0);
      chk("rst_fail_count", fail_count, 0);
      chk("rst_cycle_count", cycle_count, 0);
      reset = 1'b0; clr = 1'b0; mon_clr = 1'b0;

      // back-to-back runs from DONE: each row must start from cleared counters
      for (int v = 0; v < 7; v++) begin
         chk_e[0] = vecs[v].e0;
         chk_e[1] = vecs[v].e1;
         halt_at  = vecs[v].halt;
         do_run(-1, ok);
         if (ok) check_res($sformatf("vec%0d", v), vecs[v].p, vecs[v].fails, vecs[v].cyc, vecs[v].t);
         chk($sformatf("vec%0d_mem120", v), mem[120], 100);
         chk($sformatf("vec%0d_mem121", v), mem[121], 145);
      end

      // start pulsed mid-RUN is ignored
      chk_e[0] = 32'd145; chk_e[1] = 32'd100; halt_at = 40;
      do_run(10, ok);
      if (ok) check_res("start_in_run", 1'b1, 0, 40, 1'b0);

      // reset in the middle of LOAD
      @(negedge clk1); start = 1'b1;
      @(negedge clk1); start = 1'b0;
      repeat (5) @(negedge clk1);
      chk("midload_we_before_reset", mem_we, 1);
      reset = 1'b1;
      @(negedge clk1);
      chk("midload_busy", busy, 0);
      chk("midload_mem_we", mem_we, 0);
      chk("midload_mem_addr", mem_addr, 0);
      chk("midload_core_run", core_run, 0);
      chk("midload_done", done, 0);
      chk("midload_img_idx", img_idx, 0);
      chk("midload_cycle_count", cycle_count, 0);
      reset = 1'b0;
      halt_at = 40;
      do_run(-1, ok);
      if (ok) check_res("after_reset", 1'b1, 0, 40, 1'b0);

      // randomized runs against the reference model
      for (int r = 0; r < 20; r++) begin
         @(negedge clk1); clr = 1'b1;
         @(negedge clk1); clr = 1'b0;
         for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
         for (int i = 0; i < PL; i++) begin
            a = 10'(100 + $urandom_range(0, 31));
            d = $urandom;
            img_tab[i] = {a, d};
            ref_mem[a] = d;
         end
         ref_mem[121] = ref_mem[120] + 32'd45;
         for (int c = 0; c < NC; c++) begin
            a = (c == 0) ? 10'd121 : 10'(100 + $urandom_range(0, 31));
            chk_a[c] = a;
            chk_e[c] = ($urandom_range(0, 1) == 1) ? ref_mem[a] : (ref_mem[a] ^ 32'h0000_0100);
         end
         halt_at = $urandom_range(0, 80);
         exp_t   = (halt_at >= TO);
         exp_cy  = exp_t ? TO : halt_at;
         exp_f   = 0;
         if (!exp_t)
            for (int c = 0; c < NC; c++)
               if (ref_mem[chk_a[c]] != chk_e[c]) exp_f++;
         do_run(-1, ok);
         if (ok) check_res($sformatf("rnd%0d", r), !exp_t && exp_f == 0, exp_f, exp_cy, exp_t);
         for (int c = 0; c < NC; c++)
            chk($sformatf("rnd%0d_mem%0d", r, c), mem[chk_a[c]], ref_mem[chk_a[c]]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
